// File: rtl/delta_loader_pkg.sv
// Shared types and helpers for the Delta input loader.
package delta_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_LO,
    S_RD_HI,
    S_WR,
    S_ADV,
    S_FINISH
  } state_e;

  localparam int ELEMS_PER_DRAM = 4;
  localparam int ELEMS_PER_SRAM = 8;

  // Round x to a multiple of 8, downward or (up=1) upward.
  function automatic logic [31:0] round8(input logic [31:0] x, input logic up);
    logic [31:0] t;
    t = up ? (x + 32'd7) : x;
    return t & ~32'd7;
  endfunction

endpackage

// File: rtl/delta_loader_idx_counter.sv
// Nested channel / row / column walker. Column steps by one SRAM word
// (8 elements), rows and channels by one. Intended for reuse by other tile loaders.
module delta_loader_idx_counter #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_ch_i,
  input  logic [W-1:0] lim_sz_i,
  output logic [W-1:0] ch_o,
  output logic [W-1:0] r_o,
  output logic [W-1:0] c_o,
  output logic         last_o
);
  import delta_loader_pkg::*;

  logic [W-1:0] ch_q, ch_d, r_q, r_d, c_q, c_d;
  logic         c_wrap, r_wrap;

  // Column fastest, then row, then channel.
  always_comb begin
    c_wrap = (c_q + W'(ELEMS_PER_SRAM)) == lim_sz_i;
    r_wrap = (r_q + W'(1)) == lim_sz_i;
    ch_d   = ch_q;
    r_d    = r_q;
    c_d    = c_q;
    if (clear_i) begin
      ch_d = '0;
      r_d  = '0;
      c_d  = '0;
    end else if (en_i) begin
      if (c_wrap) begin
        c_d = '0;
        if (r_wrap) begin
          r_d  = '0;
          ch_d = ch_q + W'(1);
        end else begin
          r_d = r_q + W'(1);
        end
      end else begin
        c_d = c_q + W'(ELEMS_PER_SRAM);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_q <= '0;
      r_q  <= '0;
      c_q  <= '0;
    end else begin
      ch_q <= ch_d;
      r_q  <= r_d;
      c_q  <= c_d;
    end
  end

  assign ch_o   = ch_q;
  assign r_o    = r_q;
  assign c_o    = c_q;
  assign last_o = c_wrap && r_wrap && ((ch_q + W'(1)) == lim_ch_i);

endmodule

// File: rtl/delta_controller_input_loader.sv
// DRAM -> Input SRAM loader: two 32-bit DRAM reads are packed into each
// 64-bit SRAM word, channel by channel in row-major order.
// Optional macro DELTA_LOADER_ZERO_PAD_EN: round sizes up and zero-fill the
// padding instead of truncating to multiples of 8.
module delta_controller_input_loader #(
  parameter int          MAX_IN_CH   = 256,
  parameter int          MAX_FEATURE = 256,
  parameter int          ELEM_W      = 8,
  parameter logic [31:0] SRAM_BASE   = 32'd0,
  localparam int         ICW         = $clog2(MAX_IN_CH) + 1,
  localparam int         SZW         = $clog2(MAX_FEATURE) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [ICW-1:0] IC_Num,
  input  logic [SZW-1:0] IRC_Size,
  input  logic [31:0]    input_start_address,
  output logic           DRAM_Read,
  output logic [31:0]    DRAM_Address,
  input  logic [31:0]    DRAM_ReadData,
  input  logic           DRAM_ReadDone,
  output logic           Input_SRAM_w_en,
  output logic [31:0]    Input_SRAM_w_addr,
  output logic [63:0]    Input_SRAM_w_d,
  input  logic           Input_SRAM_w_done,
  output logic           busy,
  output logic           finished
);
  import delta_loader_pkg::*;

  // One spare bit so round-up of the widest size still fits.
  localparam int          CW        = ((ICW > SZW) ? ICW : SZW) + 1;
  localparam logic [31:0] DRAM_STEP = 32'(ELEMS_PER_DRAM * ELEM_W / 8);

  state_e         state_q, state_d;
  logic [CW-1:0]  eff_ch_q, eff_ch_d, eff_sz_q, eff_sz_d;
  logic [31:0]    dram_addr_q, dram_addr_d, sram_addr_q, sram_addr_d;
  logic [31:0]    lo_q, lo_d, hi_q, hi_d;
  logic           cnt_clr, cnt_en;
  logic [CW-1:0]  ch, r, c;
  logic           last;
  logic           lo_skip, hi_skip;
  logic [31:0]    lo_mask, hi_mask;
  logic           pad_up;
  logic           unused_idx;

  delta_loader_idx_counter #(.W(CW)) u_idx (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (cnt_clr),
    .en_i     (cnt_en),
    .lim_ch_i (eff_ch_q),
    .lim_sz_i (eff_sz_q),
    .ch_o     (ch),
    .r_o      (r),
    .c_o      (c),
    .last_o   (last)
  );

  // Completion is decided from ch against eff_ch; last is kept for other loaders.
  assign unused_idx = ^{r, c, last};

`ifdef DELTA_LOADER_ZERO_PAD_EN
  logic [ICW-1:0] ic_q;
  logic [SZW-1:0] sz_q;
  logic           pad_word;

  assign pad_up = 1'b1;

  // Raw sizes are needed to locate the padding region.
  always_ff @(posedge clock) begin
    if (reset) begin
      ic_q <= '0;
      sz_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      ic_q <= IC_Num;
      sz_q <= IRC_Size;
    end
  end

  // Skip decisions and per-byte masks for the current word's two halves.
  always_comb begin
    pad_word = (ch >= CW'(ic_q)) || (r >= CW'(sz_q));
    lo_skip  = pad_word || (c >= CW'(sz_q));
    hi_skip  = pad_word || ((c + CW'(ELEMS_PER_DRAM)) >= CW'(sz_q));
    lo_mask  = '0;
    hi_mask  = '0;
    for (int k = 0; k < ELEMS_PER_DRAM; k++) begin
      lo_mask[k*ELEM_W +: ELEM_W] =
        ((c + CW'(k)) < CW'(sz_q)) ? {ELEM_W{1'b1}} : {ELEM_W{1'b0}};
      hi_mask[k*ELEM_W +: ELEM_W] =
        ((c + CW'(ELEMS_PER_DRAM + k)) < CW'(sz_q)) ? {ELEM_W{1'b1}} : {ELEM_W{1'b0}};
    end
  end
`else
  assign pad_up  = 1'b0;
  assign lo_skip = 1'b0;
  assign hi_skip = 1'b0;
  assign lo_mask = '1;
  assign hi_mask = '1;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    eff_ch_d    = eff_ch_q;
    eff_sz_d    = eff_sz_q;
    dram_addr_d = dram_addr_q;
    sram_addr_d = sram_addr_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          eff_ch_d    = CW'(round8(32'(IC_Num), pad_up));
          eff_sz_d    = CW'(round8(32'(IRC_Size), pad_up));
          dram_addr_d = input_start_address;
          sram_addr_d = SRAM_BASE;
          cnt_clr     = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ch == eff_ch_q || eff_sz_q == '0) begin
          state_d = S_FINISH;
        end else if (lo_skip) begin
          // lo skipped implies hi skipped: column c+4 is past c.
          lo_d    = '0;
          hi_d    = '0;
          state_d = S_WR;
        end else begin
          state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (DRAM_ReadDone) begin
          lo_d        = DRAM_ReadData & lo_mask;
          dram_addr_d = dram_addr_q + DRAM_STEP;
          if (hi_skip) begin
            hi_d    = '0;
            state_d = S_WR;
          end else begin
            state_d = S_RD_HI;
          end
        end
      end
      S_RD_HI: begin
        if (DRAM_ReadDone) begin
          hi_d        = DRAM_ReadData & hi_mask;
          dram_addr_d = dram_addr_q + DRAM_STEP;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (Input_SRAM_w_done) state_d = S_ADV;
      end
      S_ADV: begin
        sram_addr_d = sram_addr_q + 32'(ELEMS_PER_SRAM);
        cnt_en      = 1'b1;
        state_d     = S_CHECK;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      eff_ch_q    <= '0;
      eff_sz_q    <= '0;
      dram_addr_q <= '0;
      sram_addr_q <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      state_q     <= state_d;
      eff_ch_q    <= eff_ch_d;
      eff_sz_q    <= eff_sz_d;
      dram_addr_q <= dram_addr_d;
      sram_addr_q <= sram_addr_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
    end
  end

  assign DRAM_Read         = (state_q == S_RD_LO) || (state_q == S_RD_HI);
  assign DRAM_Address      = dram_addr_q;
  assign Input_SRAM_w_en   = (state_q == S_WR);
  assign Input_SRAM_w_addr = sram_addr_q;
  assign Input_SRAM_w_d    = {hi_q, lo_q};
  assign busy              = (state_q != S_IDLE);
  assign finished          = (state_q == S_FINISH);

endmodule

// File: tb/tb_delta_controller_input_loader.sv
// Bench for delta_controller_input_loader: memory responders with
// programmable latency, a scoreboard of expected DRAM reads and SRAM writes.
`timescale 1ns/1ps
module tb_delta_controller_input_loader;
  localparam int ICW = 9;
  localparam int SZW = 9;
`ifdef DELTA_LOADER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [ICW-1:0] IC_Num = '0;
  logic [SZW-1:0] IRC_Size = '0;
  logic [31:0]    input_start_address = '0;
  logic           DRAM_Read, DRAM_ReadDone;
  logic [31:0]    DRAM_Address, DRAM_ReadData;
  logic           Input_SRAM_w_en, Input_SRAM_w_done;
  logic [31:0]    Input_SRAM_w_addr;
  logic [63:0]    Input_SRAM_w_d;
  logic           busy, finished;

  delta_controller_input_loader dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .IC_Num              (IC_Num),
    .IRC_Size            (IRC_Size),
    .input_start_address (input_start_address),
    .DRAM_Read           (DRAM_Read),
    .DRAM_Address        (DRAM_Address),
    .DRAM_ReadData       (DRAM_ReadData),
    .DRAM_ReadDone       (DRAM_ReadDone),
    .Input_SRAM_w_en     (Input_SRAM_w_en),
    .Input_SRAM_w_addr   (Input_SRAM_w_addr),
    .Input_SRAM_w_d      (Input_SRAM_w_d),
    .Input_SRAM_w_done   (Input_SRAM_w_done),
    .busy                (busy),
    .finished            (finished)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, a[15:0]};
  endfunction

  // Memory responders: done after 'lat' extra cycles of a held request.
  int dlat = 0, slat = 0, dcnt = 0, scnt = 0;
  always @(posedge clock) begin
    dcnt <= (DRAM_Read && !DRAM_ReadDone) ? dcnt + 1 : 0;
    scnt <= (Input_SRAM_w_en && !Input_SRAM_w_done) ? scnt + 1 : 0;
  end
  assign DRAM_ReadDone     = DRAM_Read && (dcnt == dlat);
  assign Input_SRAM_w_done = Input_SRAM_w_en && (scnt == slat);
  assign DRAM_ReadData     = memf(DRAM_Address);

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_w[$];
  logic [31:0] exp_rd[$];
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, fin_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on each completed handshake.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (DRAM_Read && prev_hold) chk("dram_addr_stable", 64'(DRAM_Address), 64'(prev_addr));
      if (DRAM_Read && DRAM_ReadDone) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL dram_unexpected_read: got addr %0h, want no read", DRAM_Address);
        end else begin
          chk("dram_addr", 64'(DRAM_Address), 64'(exp_rd.pop_front()));
        end
      end
      if (Input_SRAM_w_en && Input_SRAM_w_done) begin
        wr_cnt++;
        if (exp_w.size() == 0) begin
          checks++; failures++;
          $display("FAIL sram_unexpected_write: got addr %0h, want no write", Input_SRAM_w_addr);
        end else begin
          wr_t e;
          e = exp_w.pop_front();
          chk("sram_w_addr", 64'(Input_SRAM_w_addr), 64'(e.addr));
          chk("sram_w_d", Input_SRAM_w_d, e.data);
        end
      end
      if (finished) fin_cnt++;
    end
    prev_hold = DRAM_Read && !DRAM_ReadDone && !reset;
    prev_addr = DRAM_Address;
  end

  // Reference model: fills the scoreboard and returns words, reads, latency.
  task automatic build(input int ic, input int sz, input logic [31:0] sa,
                       input int d, input int s,
                       output int nw, output int nr, output int lat);
    int ech, esz, stride, col, rd;
    logic [31:0] rda, a, v;
    logic [31:0] half[2];
    ech    = PAD ? ((ic + 7) / 8) * 8 : (ic / 8) * 8;
    esz    = PAD ? ((sz + 7) / 8) * 8 : (sz / 8) * 8;
    stride = (sz + 3) / 4;
    rda = sa; nw = 0; nr = 0; lat = 2;
    if (esz == 0) ech = 0;
    for (int ch = 0; ch < ech; ch++)
      for (int r = 0; r < esz; r++)
        for (int c = 0; c < esz; c += 8) begin
          rd = 0;
          for (int h = 0; h < 2; h++) begin
            col = c + 4 * h;
            if (!PAD) begin
              half[h] = memf(rda); exp_rd.push_back(rda); rda += 32'd4; rd++;
            end else if (ch >= ic || r >= sz || col >= sz) begin
              half[h] = '0;
            end else begin
              a = sa + 32'(4 * ((ch * sz + r) * stride + col / 4));
              exp_rd.push_back(a); rd++;
              v = memf(a);
              for (int k = 0; k < 4; k++) if (col + k >= sz) v[k*8 +: 8] = 8'h00;
              half[h] = v;
            end
          end
          exp_w.push_back('{addr: 32'(8 * nw), data: {half[1], half[0]}});
          nr += rd; nw++;
          lat += 3 + s + rd * (1 + d);
        end
  endtask

  // One full load; poke=1 pulses start during a WR and the following ADV.
  task automatic run(input int ic, input int sz, input logic [31:0] sa,
                     input int d, input int s, input int exp_words, input bit poke);
    int nw, nr, lat, cyc, w0, r0, f0, pst;
    bit done;
    dlat = d; slat = s;
    build(ic, sz, sa, d, s, nw, nr, lat);
    w0 = wr_cnt; r0 = rd_cnt; f0 = fin_cnt;
    @(negedge clock);
    IC_Num = ICW'(ic); IRC_Size = SZW'(sz); input_start_address = sa; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    IC_Num = '1; IRC_Size = 9'd3; input_start_address = 32'hDEAD_0000;
    cyc = 1; done = 1'b0; pst = 0;
    while (!done && cyc < lat + 100) begin
      if (finished) done = 1'b1;
      else begin
        if (poke) begin
          if (pst == 0 && Input_SRAM_w_en) begin start = 1'b1; pst = 1; end
          else if (pst == 1) pst = 2;
          else if (pst == 2) begin start = 1'b0; pst = 3; end
        end
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL finish_timeout: got no finished in %0d cycles, want %0d", cyc, lat);
    end else begin
      chk("latency", 64'(cyc), 64'(lat));
    end
    repeat (6) @(negedge clock);
    chk("words_written", 64'(wr_cnt - w0), 64'(exp_words));
    chk("dram_reads", 64'(rd_cnt - r0), 64'(nr));
    chk("finished_pulses", 64'(fin_cnt - f0), 64'd1);
    chk("idle_no_read", 64'(DRAM_Read), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
    chk("sb_writes_left", 64'(exp_w.size()), 64'd0);
    chk("sb_reads_left", 64'(exp_rd.size()), 64'd0);
    exp_w.delete(); exp_rd.delete();
  endtask

  typedef struct {
    int          ic;
    int          sz;
    logic [31:0] sa;
    int          d;
    int          s;
    int          w_nopad;
    int          w_pad;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int nw, nr, lat, w0, r0, cyc;
    vecs[0] = '{8,  8, 32'h0000_1000, 0, 0, 64,  64};
    vecs[1] = '{8,  8, 32'h0000_1000, 3, 0, 64,  64};
    vecs[2] = '{5,  8, 32'h0000_4000, 0, 0, 0,   64};
    vecs[3] = '{8,  7, 32'h0000_4000, 0, 0, 0,   64};
    vecs[4] = '{16, 8, 32'hFFFF_FF00, 1, 2, 128, 128};
    vecs[5] = '{1,  6, 32'h0000_8000, 0, 1, 0,   64};
    vecs[6] = '{0,  0, 32'h0000_0100, 0, 0, 0,   0};
    vecs[7] = '{9, 17, 32'h0001_0000, 0, 0, 256, 1152};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_dram_read", 64'(DRAM_Read), 64'd0);
    chk("rst_w_en", 64'(Input_SRAM_w_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    chk("rst_dram_addr", 64'(DRAM_Address), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run(vecs[i].ic, vecs[i].sz, vecs[i].sa, vecs[i].d, vecs[i].s,
          PAD ? vecs[i].w_pad : vecs[i].w_nopad, 1'b0);

    // start pulses while busy must not restart or add a finished pulse.
    run(8, 8, 32'h0000_1000, 0, 0, 64, 1'b1);

    // Reset in the first cycle of the 10th word's RD_HI.
    dlat = 2; slat = 0;
    build(8, 8, 32'h0000_3000, 2, 0, nw, nr, lat);
    w0 = wr_cnt; r0 = rd_cnt;
    @(negedge clock);
    IC_Num = 9'd8; IRC_Size = 9'd8; input_start_address = 32'h0000_3000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!(rd_cnt - r0 == 19 && DRAM_Read && dcnt == 0) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 2000) begin
      checks++; failures++;
      $display("FAIL reset_point_timeout: got %0d reads, want 19", rd_cnt - r0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_dram_read", 64'(DRAM_Read), 64'd0);
    chk("mid_rst_w_en", 64'(Input_SRAM_w_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_finished", 64'(finished), 64'd0);
    chk("mid_rst_dram_addr", 64'(DRAM_Address), 64'd0);
    chk("mid_rst_w_addr", 64'(Input_SRAM_w_addr), 64'd0);
    chk("mid_rst_w_d", Input_SRAM_w_d, 64'd0);
    reset = 1'b0;
    exp_w.delete(); exp_rd.delete();
    repeat (4) @(negedge clock);
    chk("mid_rst_words", 64'(wr_cnt - w0), 64'd9);
    chk("mid_rst_reads", 64'(rd_cnt - r0), 64'd19);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    run(8, 8, 32'h0000_2000, 0, 0, 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_controller_input_loader.md
Name: delta_controller_input_loader

Overview:
DRAM-to-input-SRAM loader; the inbound counterpart of the output extractor.
- Fetches an IC × R × R feature map from DRAM as 32-bit reads.
- Packs each pair of reads into one 64-bit word and writes it to the Input SRAM, one row-major channel at a time.
- Sits between the DRAM port and the Input SRAM write port under the Delta top-level controller; reports completion with a one-cycle `finished` pulse.

Parameters:
- MAX_IN_CH, 256, max input channels; width of IC_Num = $clog2(MAX_IN_CH)+1.
- MAX_FEATURE, 256, max row/col size; width of IRC_Size = $clog2(MAX_FEATURE)+1.
- ELEM_W, 8, bits per element; 4 elements per DRAM word, 8 per SRAM word.
- SRAM_BASE, 0, first Input SRAM element address written.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin load; sampled only in IDLE
- IC_Num  in  $clog2(MAX_IN_CH)+1  channel count
- IRC_Size  in  $clog2(MAX_FEATURE)+1  rows = cols
- input_start_address  in  32  DRAM byte address of element (0,0,0)
- DRAM_Read  out  1  read request, held until DRAM_ReadDone
- DRAM_Address  out  32  read byte address
- DRAM_ReadData  in  32  read data, valid when DRAM_ReadDone=1
- DRAM_ReadDone  in  1  one-cycle completion strobe
- Input_SRAM_w_en  out  1  write request, held until Input_SRAM_w_done
- Input_SRAM_w_addr  out  32  element address
- Input_SRAM_w_d  out  64  {hi_word, lo_word}
- Input_SRAM_w_done  in  1  one-cycle completion strobe
- busy  out  1  high in any non-IDLE state
- finished  out  1  one-cycle completion pulse

Behaviour:
- On `start` in IDLE, latch the following:
  - eff_ch = IC_Num rounded down to a multiple of 8.
  - eff_sz = IRC_Size rounded down to a multiple of 8.
  - dram_addr = input_start_address; sram_addr = SRAM_BASE.
  - Counters ch = r = c = 0.
- Later input changes are ignored until the next start.
- Ranges are exclusive: ch < eff_ch, r < eff_sz, c < eff_sz. c steps by 8.
- FSM states: IDLE, CHECK, RD_LO, RD_HI, WR, ADV, FINISH.
  - IDLE: on start → CHECK.
  - CHECK: if ch == eff_ch (includes eff_ch == 0 or eff_sz == 0) → FINISH; else → RD_LO.
  - RD_LO: DRAM_Read = 1. On ReadDone, capture lo_word, dram_addr += 4, → RD_HI.
  - RD_HI: same as RD_LO; captures hi_word, → WR.
  - WR: Input_SRAM_w_en = 1, w_d = {hi_word, lo_word}. On w_done → ADV.
  - ADV: one cycle. sram_addr += 8; c += 8. When c wraps (c + 8 == eff_sz): c = 0, r++. When r also wraps: r = 0, ch++. → CHECK.
  - FINISH: finished = 1 for one cycle → IDLE.
- Minimum cost per SRAM word is 5 cycles (RD_LO, RD_HI, WR, ADV, CHECK) with single-cycle handshakes. Each extra cycle of DRAM or SRAM latency adds one cycle.
- A done strobe arriving in the same cycle the request is first asserted is accepted.
- Strobes in states that do not expect them are ignored.
- DRAM_Address and Input_SRAM_w_addr are registered and stable while their request is high.
- Address arithmetic is 32-bit and wraps modulo 2^32; no error is flagged.
- Reset, including mid-transfer, forces the following in the next cycle:
  - State = IDLE; DRAM_Read, Input_SRAM_w_en, busy and finished = 0.
  - Counters = 0; lo_word and hi_word = 0; addresses = 0.
  - No pending request is completed.
- `start` while busy is ignored.

Optional Feature:
DELTA_LOADER_ZERO_PAD_EN.
- Defined:
  - eff_ch and eff_sz round up to a multiple of 8.
  - DRAM rows are strided at ceil(IRC_Size/4) words.
  - Elements with column ≥ IRC_Size are forced to 0 in the packed word.
  - A DRAM half whose first column is ≥ IRC_Size is skipped: no DRAM_Read, no address increment, half = 0. The padded-channel rule below takes priority.
  - Channels ≥ IC_Num, and rows ≥ IRC_Size, produce all-zero words with no DRAM reads.
- Undefined: round-down behaviour as above.

Decomposition:
- Package delta_loader_pkg:
  - State enum.
  - Constants ELEMS_PER_DRAM = 4, ELEMS_PER_SRAM = 8.
  - Function `round8(x, up)`.
- Sub-module delta_loader_idx_counter: ch/r/c nested counter with an enable input and a `last` output, shared with future tile loaders.

Test Plan:
- IC=8, R=8, start_addr=0x1000, zero-latency memory → 64 SRAM writes, w_addr 0..504 step 8, 128 DRAM reads 0x1000..0x11FC, finished pulses once, no further requests.
- IC=8, R=8, DRAM_ReadDone delayed 3 cycles each → DRAM_Read held 4 cycles per read with stable address; per-word cost 11 cycles; same data as the zero-latency case.
- IC=5 or R=7 (macro off) → zero SRAM writes and zero DRAM reads, finished 2 cycles after start.
- Reset asserted in RD_HI of the 10th word → next cycle all outputs 0 and state IDLE. A new start with IC=8, R=8, start_addr=0x2000 → reloads from address 0x2000, first w_addr = 0.
- DELTA_LOADER_ZERO_PAD_EN, IC=1, R=6 → eff 8×8: 8 words per channel. Rows 0–5 each use 2 DRAM reads (stride 8 bytes) and bytes 6–7 are 0; rows 6–7 and channels 1–7 are all-zero words with no reads.
- `start` pulsed in WR and again in ADV → ignored; exactly one finished pulse.
